edge_event_gen: RTL
===================

Name: edge_event_gen

Overview:
- Stimulus-side counterpart to mixed-sensitivity event monitors (any-edge on level lines, posedge-only on edge lines).
- Accepts timed transition commands over a valid/ready interface and drives a bank of single-bit event lines one transition at a time.
- Maintains a running count of events a mixed-sensitivity monitor must see, so a checker compares monitor count against `expect_cnt`.
- Used in regression benches and as a self-checking event source.

Parameters:
- NUM_LINES, 3, number of driven event lines (2..4).
- DELAY_W, 8, width of the per-command delay field.
- CNT_W, 8, width of the expected-event counter.
- POSEDGE_MASK, 3'b100, bit i set means line i counts posedges only; clear means line i counts any change.

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_line  in  2  target line index
- cmd_op  in  2  00 = set 0, 01 = set 1, 10 = toggle, 11 = delay-only (no line change)
- cmd_delay  in  DELAY_W  idle cycles before the transition
- lines_out  out  NUM_LINES  driven event lines
- busy  out  1  command in flight
- done_pulse  out  1  one-cycle strobe when a command retires
- expect_cnt  out  CNT_W  expected monitor event count
- err  out  1  sticky bad-line flag

Behaviour:
- Reset: clk and reset only; reset is synchronous and active-high. On the reset edge, all outputs and state are set:
  - lines_out = 0, expect_cnt = 0, err = 0, done_pulse = 0, busy = 0.
  - State = IDLE; cmd_ready = 1 the cycle after reset deasserts.
- States: IDLE, WAIT.
  - IDLE: cmd_ready = 1, busy = 0. Handshake on a clock edge with cmd_valid && cmd_ready.
  - On handshake: latch line/op/delay, load a down-counter with cmd_delay, go to WAIT.
  - WAIT: cmd_ready = 0, busy = 1. Counter nonzero: decrement. Counter zero: apply the transition and return to IDLE on that edge.
- Latency:
  - Handshake at edge T means lines_out changes at edge T+1+cmd_delay.
  - done_pulse is high for exactly the cycle following that edge; cmd_ready is also high in that cycle.
  - Back-to-back throughput: one command per cmd_delay+2 cycles.
- Event accounting at apply, per line i with old value o and new value n:
  - POSEDGE_MASK[i] = 0: count +1 if o != n.
  - POSEDGE_MASK[i] = 1: count +1 only if o = 0 and n = 1.
  - A set to the current value, or op 11, gives no change and no count.
- Counter arithmetic: expect_cnt is modulo 2^CNT_W; 2^CNT_W-1 plus one event gives 0 with no flag.
- Bad line index (cmd_line >= NUM_LINES):
  - Handshake and delay proceed normally; no line change and no count.
  - done_pulse still fires; err is set and held until reset.
- Op 11: cmd_line is ignored (never sets err); useful as a pure timing gap.
- Handshake timing: cmd_valid while busy is ignored; cmd_* only needs to be stable on the handshake edge.
- Reset mid-WAIT: the pending command is dropped, with no transition, no done_pulse and no count. Outputs return to reset values on that edge.
- Only one line changes per command, so simultaneous changes on multiple lines never occur.

Test Plan:
- Directed sequence after reset (matches the canonical monitor check). Required lines_out and expect_cnt after each command:
  - line0 set0, delay 0 -> lines_out 000, expect_cnt 0.
  - line2 set1 -> 100, expect_cnt 1.
  - line2 set0 -> 000, expect_cnt 1.
  - line1 set1 -> 010, expect_cnt 2.
- Latency: handshake line0 toggle with delay 5 at edge T -> lines_out[0] rises at edge T+6; done_pulse high the following cycle only; cmd_ready low T+1..T+5.
- Counter wrap: 256 toggles on line0 with delay 0 -> expect_cnt returns to 0; every done_pulse observed exactly once, spaced 2 cycles apart.
- Reset mid-operation: line1 set1 with delay 10, reset asserted 4 cycles after handshake -> lines_out 000, expect_cnt 0, no done_pulse, cmd_ready = 1 the cycle after reset deasserts.
- Bad index and op 11:
  - cmd_line 3 set1 -> err = 1, lines unchanged, done_pulse fires.
  - Op 11 with cmd_line 3 -> err unchanged, expect_cnt unchanged.
- Handshake robustness: cmd_valid held high with changing payloads while busy -> only the payload on each handshake edge is executed; the count matches a hand-computed sequence of 8 commands.

Source files
------------

// File: rtl/edge_event_gen.sv
// edge_event_gen
//   Timed single-line transition source for mixed-sensitivity event monitors.
//   It accepts one command at a time over valid/ready. It waits cmd_delay
//   idle cycles and then applies one transition to one line. It also keeps
//   a running count of the events that a monitor must observe. That count is
//   posedges only on lines flagged in POSEDGE_MASK and any change on the
//   other lines.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   cmd_valid/ready   command handshake
//   cmd_line          target line index (>= NUM_LINES flags err unless op 11)
//   cmd_op            00 set0, 01 set1, 10 toggle, 11 delay-only
//   cmd_delay         idle cycles before the transition is applied
//   lines_out         driven event lines
//   busy              command in flight
//   done_pulse        one-cycle strobe in the cycle after a command retires
//   expect_cnt        expected monitor event count (wraps modulo 2^CNT_W)
//   err               sticky bad-line flag

// Per-line transition: computes the next value of one line and whether that
// change is an event for the monitor.
module edge_event_gen_lane #(
  parameter bit POSEDGE_ONLY = 1'b0
) (
  input  logic       cur,
  input  logic       sel,
  input  logic [1:0] op,
  output logic       nxt,
  output logic       evt
);
  always_comb begin
    nxt = cur;
    if (sel) begin
      case (op)
        2'b00:   nxt = 1'b0;
        2'b01:   nxt = 1'b1;
        2'b10:   nxt = ~cur;
        default: nxt = cur;
      endcase
    end
    evt = POSEDGE_ONLY ? (~cur & nxt) : (cur ^ nxt);
  end
endmodule

module edge_event_gen #(
  parameter int                    NUM_LINES    = 3,
  parameter int                    DELAY_W      = 8,
  parameter int                    CNT_W        = 8,
  parameter logic [NUM_LINES-1:0]  POSEDGE_MASK = 3'b100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_line,
  input  logic [1:0]           cmd_op,
  input  logic [DELAY_W-1:0]   cmd_delay,
  output logic [NUM_LINES-1:0] lines_out,
  output logic                 busy,
  output logic                 done_pulse,
  output logic [CNT_W-1:0]     expect_cnt,
  output logic                 err
);
  localparam logic [2:0] NL = 3'(NUM_LINES);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic [1:0] line;
    logic [1:0] op;
  } cmd_t;

  state_t               state;
  cmd_t                 cmd_q;
  logic [DELAY_W-1:0]   dcnt_q;

  logic                 apply;
  logic                 is_nop;
  logic                 line_ok;
  logic [NUM_LINES-1:0] lines_nxt;
  logic [NUM_LINES-1:0] evt;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state == S_WAIT);

  // The transition lands on the edge where the delay counter is already zero.
  // That puts the change at handshake + 1 + cmd_delay.
  assign apply   = (state == S_WAIT) && (dcnt_q == '0);
  assign is_nop  = (cmd_q.op == 2'b11);
  assign line_ok = ({1'b0, cmd_q.line} < NL);

  // Only the addressed lane is selected, so at most one evt bit is set.
  // An out-of-range index selects no lane.
  for (genvar i = 0; i < NUM_LINES; i++) begin : g_lane
    edge_event_gen_lane #(.POSEDGE_ONLY(POSEDGE_MASK[i])) u_lane (
      .cur (lines_out[i]),
      .sel (apply && !is_nop && (cmd_q.line == 2'(i))),
      .op  (cmd_q.op),
      .nxt (lines_nxt[i]),
      .evt (evt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cmd_q      <= '0;
      dcnt_q     <= '0;
      lines_out  <= '0;
      expect_cnt <= '0;
      err        <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_q  <= '{line: cmd_line, op: cmd_op};
            dcnt_q <= cmd_delay;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!apply) begin
            dcnt_q <= dcnt_q - 1'b1;
          end else begin
            lines_out  <= lines_nxt;
            expect_cnt <= expect_cnt + CNT_W'(|evt);
            if (!is_nop && !line_ok) err <= 1'b1;
            done_pulse <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
